// File: rtl/cache_req_arb_if.sv
//-----------------------------------------------------------------------------
// Module   : cache_req_arb_if
// Purpose  : Two requester ports plus the cache packet/response bus.
// Revision : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

interface cache_req_arb_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              p0_req_valid;
  logic              p0_req_ready;
  logic [ADDR_W-1:0] p0_req_addr;
  logic              p0_req_we;
  logic [DATA_W-1:0] p0_req_wdat;
  logic              p0_rsp_valid;
  logic [DATA_W-1:0] p0_rsp_rdata;

  logic              p1_req_valid;
  logic              p1_req_ready;
  logic [ADDR_W-1:0] p1_req_addr;
  logic              p1_req_we;
  logic [DATA_W-1:0] p1_req_wdat;
  logic              p1_rsp_valid;
  logic [DATA_W-1:0] p1_rsp_rdata;

  logic              c_valid;
  logic [ADDR_W-1:0] c_addr;
  logic              c_we;
  logic [DATA_W-1:0] c_wdat;
  logic              c_ready;
  logic              c_rsp_valid;
  logic [DATA_W-1:0] c_rdata;

  modport slave (
    input  p0_req_valid, p0_req_addr, p0_req_we, p0_req_wdat,
    output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
    input  p1_req_valid, p1_req_addr, p1_req_we, p1_req_wdat,
    output p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
    output c_valid, c_addr, c_we, c_wdat,
    input  c_ready, c_rsp_valid, c_rdata
  );

  modport master (
    output p0_req_valid, p0_req_addr, p0_req_we, p0_req_wdat,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
    output p1_req_valid, p1_req_addr, p1_req_we, p1_req_wdat,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
    input  c_valid, c_addr, c_we, c_wdat,
    output c_ready, c_rsp_valid, c_rdata
  );
endinterface

`default_nettype wire

// File: rtl/cache_req_arb.sv
//-----------------------------------------------------------------------------
// Module   : cache_req_arb
// Purpose  : Two-port arbiter into a single-outstanding cache request path.
//            CACHE_ARB_RR_EN selects round-robin; otherwise port 1 has priority.
// Revision : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module cache_req_arb #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cache_req_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              port_q, port_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win;

`ifdef CACHE_ARB_RR_EN
  logic ptr_q, ptr_d;

  // Pointer names the port that wins the next tie.
  always_comb begin
    if (bus.p0_req_valid && bus.p1_req_valid) begin
      win = ptr_q;
    end else begin
      win = bus.p1_req_valid;
    end
    ptr_d = ptr_q;
    if (state_q == IDLE && (bus.p0_req_valid || bus.p1_req_valid)) begin
      ptr_d = ~win;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win = bus.p1_req_valid;
  end
`endif

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    we_d             = we_q;
    wdat_d           = wdat_q;
    port_d           = port_q;
    rdata_d          = rdata_q;
    bus.p0_req_ready = 1'b0;
    bus.p1_req_ready = 1'b0;
    bus.p0_rsp_valid = 1'b0;
    bus.p1_rsp_valid = 1'b0;
    bus.p0_rsp_rdata = '0;
    bus.p1_rsp_rdata = '0;
    bus.c_valid      = 1'b0;
    bus.c_addr       = '0;
    bus.c_we         = 1'b0;
    bus.c_wdat       = '0;

    case (state_q)
      IDLE: begin
        if (bus.p0_req_valid || bus.p1_req_valid) begin
          bus.p0_req_ready = ~win;
          bus.p1_req_ready = win;
          addr_d  = win ? bus.p1_req_addr : bus.p0_req_addr;
          we_d    = win ? bus.p1_req_we   : bus.p0_req_we;
          wdat_d  = win ? bus.p1_req_wdat : bus.p0_req_wdat;
          port_d  = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.c_valid = 1'b1;
        bus.c_addr  = addr_q;
        bus.c_we    = we_q;
        bus.c_wdat  = wdat_q;
        if (bus.c_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.c_rsp_valid) begin
          // Writes complete with zero data regardless of what the cache returns.
          rdata_d = we_q ? '0 : bus.c_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.p0_rsp_valid = ~port_q;
        bus.p1_rsp_valid = port_q;
        bus.p0_rsp_rdata = port_q ? '0 : rdata_q;
        bus.p1_rsp_rdata = port_q ? rdata_q : '0;
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      port_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      port_q  <= port_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_req_arb.sv
//-----------------------------------------------------------------------------
// Module   : tb_cache_req_arb
// Purpose  : Vector table plus hand sequences for cache_req_arb.
// Revision : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_cache_req_arb;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_req_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_req_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic              port;
    logic [DATA_W-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic              rst_before;
    logic              v0;
    logic              v1;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] cdata;
    logic [DATA_W-1:0] exp_rdata;
    int                rdy_dly;
    int                rsp_dly;
    logic              exp_rr;
    logic              exp_fp;
  } vec_t;
  vec_t vecs[8];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Response scoreboard: every pulse must match the oldest outstanding grant.
  always @(negedge clk) begin
    exp_t e;
    if (bus.p0_rsp_valid) begin
      if (sb.size() == 0) check("unexpected_rsp_p0", 64'(1), 64'(0));
      else begin
        e = sb.pop_front();
        check("rsp_port_p0", 64'(1'b0), 64'(e.port));
        check("rsp_rdata_p0", 64'(bus.p0_rsp_rdata), 64'(e.rdata));
      end
    end else check("p0_rdata_quiet", 64'(bus.p0_rsp_rdata), 64'(0));
    if (bus.p1_rsp_valid) begin
      if (sb.size() == 0) check("unexpected_rsp_p1", 64'(1), 64'(0));
      else begin
        e = sb.pop_front();
        check("rsp_port_p1", 64'(1'b1), 64'(e.port));
        check("rsp_rdata_p1", 64'(bus.p1_rsp_rdata), 64'(e.rdata));
      end
    end else check("p1_rdata_quiet", 64'(bus.p1_rsp_rdata), 64'(0));
  end

  task automatic check_all_zero(string tag);
    check({tag, "_c_valid"}, 64'(bus.c_valid), 64'(0));
    check({tag, "_c_addr"}, 64'(bus.c_addr), 64'(0));
    check({tag, "_c_we"}, 64'(bus.c_we), 64'(0));
    check({tag, "_c_wdat"}, 64'(bus.c_wdat), 64'(0));
    check({tag, "_ready0"}, 64'(bus.p0_req_ready), 64'(0));
    check({tag, "_ready1"}, 64'(bus.p1_req_ready), 64'(0));
    check({tag, "_rsp0"}, 64'(bus.p0_rsp_valid), 64'(0));
    check({tag, "_rsp1"}, 64'(bus.p1_rsp_valid), 64'(0));
  endtask

  // Entered and left at posedge+1; immediate cache timing gives rsp 3 cycles after accept.
  task automatic txn(input vec_t v);
    logic exp_port;
`ifdef CACHE_ARB_RR_EN
    exp_port = v.exp_rr;
`else
    exp_port = v.exp_fp;
`endif
    if (v.rst_before) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    bus.p0_req_valid = v.v0;
    bus.p1_req_valid = v.v1;
    bus.p0_req_addr  = v.addr;
    bus.p1_req_addr  = v.addr;
    bus.p0_req_we    = v.we;
    bus.p1_req_we    = v.we;
    bus.p0_req_wdat  = v.wdat;
    bus.p1_req_wdat  = v.wdat;
    @(negedge clk);
    check("idle_rsp0", 64'(bus.p0_rsp_valid), 64'(0));
    check("idle_rsp1", 64'(bus.p1_rsp_valid), 64'(0));
    check("idle_c_valid", 64'(bus.c_valid), 64'(0));
    check("grant_p0", 64'(bus.p0_req_ready), 64'(!exp_port));
    check("grant_p1", 64'(bus.p1_req_ready), 64'(exp_port));
    sb.push_back('{port: exp_port, rdata: v.exp_rdata});
    @(posedge clk); #1;
    if (exp_port) bus.p1_req_valid = 1'b0;
    else          bus.p0_req_valid = 1'b0;
    for (int d = 0; d <= v.rdy_dly; d++) begin
      @(negedge clk);
      check("issue_c_valid", 64'(bus.c_valid), 64'(1));
      check("issue_c_addr", 64'(bus.c_addr), 64'(v.addr));
      check("issue_c_we", 64'(bus.c_we), 64'(v.we));
      check("issue_c_wdat", 64'(bus.c_wdat), 64'(v.wdat));
      check("issue_ready0", 64'(bus.p0_req_ready), 64'(0));
      check("issue_ready1", 64'(bus.p1_req_ready), 64'(0));
      bus.c_ready = (d == v.rdy_dly);
      @(posedge clk); #1;
      bus.c_ready = 1'b0;
    end
    for (int d = 0; d < v.rsp_dly; d++) begin
      @(negedge clk);
      check("wait_c_valid", 64'(bus.c_valid), 64'(0));
      check("wait_c_addr", 64'(bus.c_addr), 64'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wait_c_valid", 64'(bus.c_valid), 64'(0));
    bus.c_rsp_valid = 1'b1;
    bus.c_rdata     = v.cdata;
    @(posedge clk); #1;
    bus.c_rsp_valid = 1'b0;
    bus.c_rdata     = DATA_W'($urandom);
    @(negedge clk);
    check("rsp_latency", 64'(exp_port ? bus.p1_rsp_valid : bus.p0_rsp_valid), 64'(1));
    check("rsp_c_valid", 64'(bus.c_valid), 64'(0));
    check("rsp_ready0", 64'(bus.p0_req_ready), 64'(0));
    check("rsp_ready1", 64'(bus.p1_req_ready), 64'(0));
    @(posedge clk); #1;
    bus.p0_req_valid = 1'b0;
    bus.p1_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{rst_before: 1, v0: 1, v1: 0, we: 0, addr: 30'h0000100, wdat: 32'h0,
                cdata: 32'hDEADBEEF, exp_rdata: 32'hDEADBEEF, rdy_dly: 0, rsp_dly: 0,
                exp_rr: 0, exp_fp: 0};
    vecs[1] = '{rst_before: 0, v0: 0, v1: 1, we: 1, addr: 30'h3FFFFFFF, wdat: 32'h12345678,
                cdata: 32'hAAAA5555, exp_rdata: 32'h0, rdy_dly: 0, rsp_dly: 0,
                exp_rr: 1, exp_fp: 1};
    vecs[2] = '{rst_before: 0, v0: 1, v1: 1, we: 0, addr: 30'h000002A, wdat: 32'h00000077,
                cdata: 32'h0BADF00D, exp_rdata: 32'h0BADF00D, rdy_dly: 5, rsp_dly: 2,
                exp_rr: 0, exp_fp: 1};
    vecs[3] = '{rst_before: 0, v0: 0, v1: 1, we: 0, addr: 30'h0, wdat: 32'h0,
                cdata: 32'hFFFFFFFF, exp_rdata: 32'hFFFFFFFF, rdy_dly: 1, rsp_dly: 0,
                exp_rr: 1, exp_fp: 1};
    vecs[4] = '{rst_before: 1, v0: 1, v1: 1, we: 0, addr: 30'h10, wdat: 32'h0,
                cdata: 32'h11111111, exp_rdata: 32'h11111111, rdy_dly: 0, rsp_dly: 0,
                exp_rr: 0, exp_fp: 1};
    vecs[5] = '{rst_before: 0, v0: 1, v1: 1, we: 1, addr: 30'h20, wdat: 32'h22222222,
                cdata: 32'h00000099, exp_rdata: 32'h0, rdy_dly: 0, rsp_dly: 0,
                exp_rr: 1, exp_fp: 1};
    vecs[6] = '{rst_before: 0, v0: 1, v1: 1, we: 0, addr: 30'h30, wdat: 32'h0,
                cdata: 32'h33333333, exp_rdata: 32'h33333333, rdy_dly: 0, rsp_dly: 0,
                exp_rr: 0, exp_fp: 1};
    vecs[7] = '{rst_before: 0, v0: 1, v1: 1, we: 0, addr: 30'h40, wdat: 32'h0,
                cdata: 32'h44444444, exp_rdata: 32'h44444444, rdy_dly: 2, rsp_dly: 1,
                exp_rr: 1, exp_fp: 1};

    bus.p0_req_valid = 1'b0; bus.p0_req_addr = '0; bus.p0_req_we = 1'b0; bus.p0_req_wdat = '0;
    bus.p1_req_valid = 1'b0; bus.p1_req_addr = '0; bus.p1_req_we = 1'b0; bus.p1_req_wdat = '0;
    bus.c_ready = 1'b0; bus.c_rsp_valid = 1'b0; bus.c_rdata = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) txn(vecs[i]);

    // Reset while waiting on the cache: the late response must vanish.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.p1_req_valid = 1'b1;
    bus.p1_req_addr  = 30'h55;
    bus.p1_req_we    = 1'b0;
    @(negedge clk);
    check("abort_grant_p1", 64'(bus.p1_req_ready), 64'(1));
    @(posedge clk); #1;
    bus.p1_req_valid = 1'b0;
    @(negedge clk);
    bus.c_ready = 1'b1;
    @(posedge clk); #1;
    bus.c_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.c_rsp_valid = 1'b1;
    bus.c_rdata     = 32'hCAFEF00D;
    @(negedge clk);
    check_all_zero("abort");
    @(posedge clk); #1;
    bus.c_rsp_valid = 1'b0;
    @(negedge clk);
    check_all_zero("abort_after");
    @(posedge clk); #1;
    v = '{rst_before: 0, v0: 1, v1: 1, we: 0, addr: 30'h66, wdat: 32'h0,
          cdata: 32'h5A5A5A5A, exp_rdata: 32'h5A5A5A5A, rdy_dly: 0, rsp_dly: 0,
          exp_rr: 0, exp_fp: 1};
    txn(v);

    // Stray cache response while idle.
    bus.c_rsp_valid = 1'b1;
    bus.c_rdata     = 32'h00001234;
    @(negedge clk);
    check_all_zero("stray");
    @(posedge clk); #1;
    bus.c_rsp_valid = 1'b0;
    @(negedge clk);
    check_all_zero("stray_after");
    @(posedge clk); #1;
    v = '{rst_before: 0, v0: 1, v1: 0, we: 0, addr: 30'h77, wdat: 32'h0,
          cdata: 32'h87654321, exp_rdata: 32'h87654321, rdy_dly: 0, rsp_dly: 0,
          exp_rr: 0, exp_fp: 0};
    txn(v);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
